acc_drain: RTL and testbench



---
 rtl/acc_drain.sv | 126 ++++++++++++
 tb/tb_acc_drain.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_drain.sv
// Accumulator drain: reads a row range, applies ReLU / rounding shift / int8 saturation per column, streams results.
// Latency: start sampled at cycle T, first out_valid at T+2; 1 row/cycle when out_ready stays high.
// Backpressure: out_ready low freezes the output register and the read pointer; the read is simply repeated.
module acc_drain #(
    parameter int ADDR_W  = 8,
    parameter int SHIFT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   row_count,
    input  logic [SHIFT_W-1:0] shift,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic              acc_rd_en,
    output logic [ADDR_W-1:0] acc_rd_addr,
    input  logic [63:0]       acc_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [ADDR_W-1:0] out_addr
);
    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t               state, state_n;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W:0]      issued;
    logic [ADDR_W:0]      count_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic                 relu_q;
    logic                 load;
    logic                 xfer;

    // 33-bit intermediate keeps x + 2^(sh-1) from overflowing for any int32 input.
    function automatic logic [7:0] requant(input logic [31:0] x,
                                           input logic [SHIFT_W-1:0] sh,
                                           input logic relu);
        logic signed [32:0] v;
        v = {x[31], x};
        if (relu && x[31])
            v = '0;
        if (sh != '0)
            v = (v + (33'sd1 <<< (sh - 1'b1))) >>> sh;
        if (v > 33'sd127)
            requant = 8'h7F;
        else if (v < -33'sd128)
            requant = 8'h80;
        else
            requant = v[7:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        xfer      = out_valid && out_ready;
        busy      = 1'b0;
        done      = 1'b0;
        acc_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_n = (row_count == '0) ? DONE : READ;
            end
            READ: begin
                busy      = 1'b1;
                acc_rd_en = 1'b1;
                load      = !out_valid || out_ready;
                if (load && ((issued + 1'b1) == count_q))
                    state_n = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (xfer)
                    state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign acc_rd_addr = rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            issued    <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            if (state == IDLE && start) begin
                rd_ptr  <= base_addr;
                issued  <= '0;
                count_q <= row_count;
                shift_q <= shift;
                relu_q  <= relu_en;
            end
            // A load in the same cycle as a transfer refills the register with no bubble.
            if (load) begin
                out_data  <= {requant(acc_rd_data[63:32], shift_q, relu_q),
                              requant(acc_rd_data[31:0], shift_q, relu_q)};
                out_addr  <= rd_ptr;
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
                issued    <= issued + 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_acc_drain.sv
// Scoreboard bench for acc_drain: stimulus pushes model results, a negedge monitor pops on each transfer.
module tb_acc_drain;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = '0;
    logic [8:0]  row_count = '0;
    logic [4:0]  shift = '0;
    logic        relu_en = 1'b0;
    logic        busy, done, acc_rd_en, out_valid;
    logic        out_ready;
    logic [7:0]  acc_rd_addr, out_addr;
    logic [63:0] acc_rd_data;
    logic [15:0] out_data;

    logic [63:0] mem [256];
    assign acc_rd_data = mem[acc_rd_addr];

    acc_drain #(.ADDR_W(8), .SHIFT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .row_count(row_count), .shift(shift), .relu_en(relu_en),
        .busy(busy), .done(done), .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
        .acc_rd_data(acc_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;
    int ready_mode = 0;
    logic [23:0] exp_q [$];
    logic        hold_prev = 1'b0;
    logic [15:0] prev_d = '0;
    logic [7:0]  prev_a = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference arithmetic on plain integers: floor((x + d/2) / d), then clamp.
    function automatic logic [7:0] model_col(input logic [31:0] raw, input int sh, input bit relu);
        longint x, n, d, y;
        x = $signed(raw);
        if (relu && x < 0)
            x = 0;
        if (sh > 0) begin
            d = longint'(1) << sh;
            n = x + d / 2;
            y = n / d;
            if (n < 0 && (n % d) != 0)
                y = y - 1;
        end else begin
            y = x;
        end
        if (y > 127)
            y = 127;
        if (y < -128)
            y = -128;
        return y[7:0];
    endfunction

    function automatic logic [15:0] model_row(input logic [63:0] r, input int sh, input bit relu);
        return {model_col(r[63:32], sh, relu), model_col(r[31:0], sh, relu)};
    endfunction

    function automatic logic [31:0] rand_col();
        case ($urandom_range(0, 2))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 600)) - 32'd300;
            default: return 32'($urandom_range(0, 2097152)) - 32'd1048576;
        endcase
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                check("stall_stable", {out_valid, out_addr, out_data}, {1'b1, prev_a, prev_d});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_xfer: got addr %h data %h want none", out_addr, out_data);
                end else begin
                    check("xfer", {out_addr, out_data}, exp_q.pop_front());
                end
                last_xfer_cyc = cyc;
            end
            hold_prev = out_valid && !out_ready;
            prev_d    = out_data;
            prev_a    = out_addr;
        end
    end

    task automatic push_rows(input int base, input int cnt, input int sh, input bit relu);
        logic [7:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = 8'(base + i);
            exp_q.push_back({a, model_row(mem[a], sh, relu)});
        end
    endtask

    task automatic run_cmd(input int base, input int cnt, input int sh, input bit relu,
                           input int rmode, input int hold, input bit poke);
        bit got;
        int c;
        int bound;
        @(negedge clk);
        ready_mode = (hold > 0) ? 2 : rmode;
        push_rows(base, cnt, sh, relu);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'(base); row_count = 9'(cnt); shift = 5'(sh); relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'($urandom); row_count = 9'($urandom_range(0, 256));
        shift = 5'($urandom); relu_en = ~relu;
        if (cnt > 0) begin
            @(negedge clk);
            check("launch", {busy, out_valid, acc_rd_en, acc_rd_addr}, {1'b1, 1'b0, 1'b1, 8'(base)});
            @(negedge clk);
            check("first_valid", out_valid, 1'b1);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("bp_rd_addr", acc_rd_addr, 8'(base + 1));
            end
            ready_mode = rmode;
        end
        if (poke) begin
            @(posedge clk); #1;
            start = 1'b1; base_addr = 8'(base + 64); row_count = 9'd5;
            @(posedge clk); #1;
            start = 1'b0;
        end
        got = 1'b0;
        bound = cnt * 8 + 40;
        for (c = 0; c < bound; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles want done", bound);
        end else if (cnt > 0) begin
            check("done_after_last", 64'(cyc - last_xfer_cyc), 64'd1);
        end else begin
            check("done_zero_count", 64'(c), 64'd0);
        end
        check("all_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk);
        check("done_pulse", {done, busy}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = {rand_col(), rand_col()};
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, acc_rd_en, out_valid, acc_rd_addr, out_addr, out_data}, 64'd0);
        rst = 1'b0;

        mem[8'h10] = {32'd5, -32'sd3};
        mem[8'h11] = {32'd100, -32'sd100};
        mem[8'h12] = {32'd127, -32'sd128};
        run_cmd(8'h10, 3, 0, 1'b0, 0, 0, 1'b0);

        mem[8'h20] = {32'hFFFF_FFE8, 32'h0000_0018};
        mem[8'h21] = {-32'sd5000, 32'sd5000};
        mem[8'h22] = {32'h8000_0000, 32'h7FFF_FFFF};
        run_cmd(8'h20, 3, 4, 1'b0, 0, 0, 1'b0);
        run_cmd(8'h20, 3, 4, 1'b1, 0, 0, 1'b0);
        run_cmd(8'h20, 3, 31, 1'b0, 0, 0, 1'b0);

        run_cmd(8'h40, 4, 3, 1'b0, 0, 3, 1'b0);
        run_cmd(8'hFE, 4, 1, 1'b0, 1, 0, 1'b0);
        run_cmd(8'h60, 0, 0, 1'b0, 0, 0, 1'b0);

        // Reset in the middle of a drain, then a fresh command from another base.
        @(negedge clk);
        ready_mode = 0;
        push_rows(8'h30, 10, 0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h30; row_count = 9'd10; shift = 5'd0; relu_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_reset", {busy, done, acc_rd_en, out_valid, acc_rd_addr, out_addr, out_data}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        run_cmd(8'h80, 5, 2, 1'b1, 0, 0, 1'b0);

        run_cmd(8'h50, 12, 2, 1'b0, 0, 0, 1'b1);

        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = {rand_col(), rand_col()};
            run_cmd($urandom_range(0, 255), $urandom_range(0, 20), $urandom_range(0, 31),
                    bit'($urandom_range(0, 1)), 1, 0, 1'b0);
        end

        run_cmd($urandom_range(0, 255), 256, $urandom_range(0, 31), bit'($urandom_range(0, 1)), 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
